// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO front-end: default geometry and the
// frame controller state encoding.
package lifo_pkg;

    localparam int unsigned LIFO_DW    = 4;
    localparam int unsigned LIFO_DEPTH = 15;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/lifo_out_buf.sv
// Two-entry skid buffer holding {last, data} words popped from the LIFO.
// The head entry drives the outputs directly, so they hold while stalled.
module lifo_out_buf
    import lifo_pkg::*;
#(
    parameter int unsigned DW = LIFO_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [1:0]    count
);

    logic [DW:0] ent0_q, ent0_d;
    logic [DW:0] ent1_q, ent1_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  wr_idx;
    logic        pop;

    assign pop = (cnt_q != 2'd0) && out_ready;

    // Pop shifts the tail into the head first; a simultaneous push then
    // lands in the slot that became free.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        wr_idx = cnt_q;
        if (pop) begin
            ent0_d = ent1_q;
            wr_idx = cnt_q - 2'd1;
            cnt_d  = cnt_q - 2'd1;
        end
        if (in_valid && (wr_idx < 2'd2)) begin
            if (wr_idx == 2'd0) begin
                ent0_d = {in_last, in_data};
            end else begin
                ent1_d = {in_last, in_data};
            end
            cnt_d = wr_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = ent0_q[DW-1:0];
    assign out_last  = ent0_q[DW];
    assign count     = cnt_q;

endmodule

// File: rtl/lifo_frame_reverser.sv
// Pushes each s_last-framed input frame into an external flagless LIFO,
// then pops it back out as a word-reversed output stream.
module lifo_frame_reverser
    import lifo_pkg::*;
#(
    parameter int unsigned DW    = LIFO_DW,
    parameter int unsigned DEPTH = LIFO_DEPTH,
    parameter int unsigned CW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic [DW-1:0] lifo_din,
    output logic          lifo_wr_en,
    output logic          lifo_rd_en,
    input  logic [DW-1:0] lifo_dout,
    output logic          ovf_err
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pop_rem_q, pop_rem_d;
    logic          inflight_q, inflight_d;
    logic          inflight_last_q, inflight_last_d;
    logic          ovf_seen_q, ovf_seen_d;

    logic          s_hs;
    logic          push;
    logic          m_hs;
    logic [1:0]    ob_cnt;
    logic [2:0]    ob_next;

    assign s_ready    = (state_q == FILL);
    assign s_hs       = s_valid && s_ready;
    assign push       = s_hs && (count_q < DEPTH_C);
    assign lifo_wr_en = push;
    assign lifo_din   = push ? s_data : '0;
    assign ovf_err    = s_hs && !push && !ovf_seen_q;

    // Buffer occupancy once this cycle's consume and last cycle's pop settle;
    // a new pop is only safe if its word will still find a free slot.
    assign m_hs       = m_valid && m_ready;
    assign ob_next    = {1'b0, ob_cnt} + {2'b0, inflight_q} - {2'b0, m_hs};
    assign lifo_rd_en = (state_q == DRAIN) && (pop_rem_q != '0) && (ob_next < 3'd2);

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        pop_rem_d       = pop_rem_q;
        ovf_seen_d      = ovf_seen_q;
        inflight_d      = lifo_rd_en;
        inflight_last_d = lifo_rd_en && (pop_rem_q == CW'(1));
        case (state_q)
            FILL: begin
                if (push) begin
                    count_d = count_q + CW'(1);
                end
                if (ovf_err) begin
                    ovf_seen_d = 1'b1;
                end
                if (s_hs && s_last) begin
                    state_d   = DRAIN;
                    pop_rem_d = count_d;
                end
            end
            DRAIN: begin
                if (lifo_rd_en) begin
                    pop_rem_d = pop_rem_q - CW'(1);
                end
                if (m_hs && m_last) begin
                    state_d    = FILL;
                    count_d    = '0;
                    ovf_seen_d = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= FILL;
            count_q         <= '0;
            pop_rem_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            ovf_seen_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            pop_rem_q       <= pop_rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            ovf_seen_q      <= ovf_seen_d;
        end
    end

    lifo_out_buf #(
        .DW(DW)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inflight_q),
        .in_data   (lifo_dout),
        .in_last   (inflight_last_q),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (m_data),
        .out_last  (m_last),
        .count     (ob_cnt)
    );

endmodule

// File: tb/tb_lifo_frame_reverser.sv
// Bench for lifo_frame_reverser: behavioural LIFO, output scoreboard and a
// frame table, plus hand sequences for back-to-back frames and reset.
module tb_lifo_frame_reverser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid, s_ready, s_last;
    logic [3:0] s_data;
    logic       m_valid, m_ready, m_last;
    logic [3:0] m_data;
    logic [3:0] lifo_din, lifo_dout;
    logic       lifo_wr_en, lifo_rd_en, ovf_err;

    always #5 clk = ~clk;

    lifo_frame_reverser #(
        .DW(4),
        .DEPTH(15),
        .CW(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .lifo_din   (lifo_din),
        .lifo_wr_en (lifo_wr_en),
        .lifo_rd_en (lifo_rd_en),
        .lifo_dout  (lifo_dout),
        .ovf_err    (ovf_err)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;
    int ready_mode = 0;

    typedef struct {
        logic [3:0] data;
        logic       last;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    typedef struct {
        int         len;
        logic [3:0] start;
        int         nout;
        logic [3:0] efirst;
        int         ovf_at;
        int         mode;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // LIFO model: commands sampled mid-cycle, applied on the edge.
    logic [3:0] lmem [16];
    int         sp;
    logic       smp_wr, smp_rd;
    logic [3:0] smp_din;

    always @(negedge clk) begin
        smp_wr  = lifo_wr_en;
        smp_rd  = lifo_rd_en;
        smp_din = lifo_din;
        if (rst_n && (lifo_wr_en || lifo_rd_en)) begin
            chk("lifo_wr_rd_excl", int'(lifo_wr_en && lifo_rd_en), 0);
            if (lifo_wr_en) chk("push_when_full", int'(sp < 15), 1);
            if (lifo_rd_en) chk("pop_when_empty", int'(sp > 0), 1);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp = 0;
            lifo_dout <= '0;
        end else if (smp_wr && sp < 16) begin
            lmem[sp] = smp_din;
            sp++;
        end else if (smp_rd && sp > 0) begin
            sp--;
            lifo_dout <= lmem[sp];
        end
    end

    // Output monitor: scoreboard compare, stall stability, input stall.
    logic       prev_stall = 1'b0;
    logic [3:0] prev_data;
    logic       prev_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            if (m_valid) chk("s_ready_in_drain", s_ready, 0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", m_data, e.data);
                    chk("m_last", m_last, e.last);
                    n_out++;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    task automatic push_expected(input logic [3:0] efirst, input int nout);
        exp_t x;
        for (int j = 0; j < nout; j++) begin
            x.data = efirst - 4'(j);
            x.last = (j == nout - 1);
            exp_q.push_back(x);
        end
    endtask

    task automatic send_frame(input int len, input logic [3:0] start, input int ovf_at);
        for (int i = 0; i < len; i++) begin
            int w = 0;
            s_valid = 1'b1;
            s_data  = start + 4'(i);
            s_last  = (i == len - 1);
            @(negedge clk);
            while (!s_ready && w < 300) begin
                chk("no_push_in_drain", lifo_wr_en, 0);
                w++;
                @(negedge clk);
            end
            if (!s_ready) begin
                chk("s_ready_timeout", s_ready, 1);
                break;
            end
            chk("lifo_wr_en", lifo_wr_en, int'(i < 15));
            if (i < 15) chk("lifo_din", lifo_din, s_data);
            chk("ovf_err", ovf_err, int'(i == ovf_at));
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    // Entered in the cycle after the s_last handshake; k counts cycles from T.
    task automatic wait_drain(input int nout, input bit timing);
        int first = -1;
        int lastk = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (m_valid && first < 0) first = k;
            if (m_valid && m_ready && m_last) begin
                lastk = k;
                break;
            end
        end
        chk("m_last_seen", int'(lastk > 0), 1);
        if (timing) begin
            chk("first_valid_latency", first, 3);
            chk("m_last_cycle", lastk, 2 + nout);
        end
        @(negedge clk);
        chk("s_ready_after_last", s_ready, 1);
        chk("m_valid_idle", m_valid, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_s_ready"}, s_ready, 1);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_lifo_wr_en"}, lifo_wr_en, 0);
        chk({tag, "_lifo_rd_en"}, lifo_rd_en, 0);
        chk({tag, "_lifo_din"}, lifo_din, 0);
        chk({tag, "_ovf_err"}, ovf_err, 0);
    endtask

    task automatic set_vec(input int idx, input int len, input logic [3:0] start,
                           input int nout, input logic [3:0] efirst,
                           input int ovf_at, input int mode);
        tbl[idx].len    = len;
        tbl[idx].start  = start;
        tbl[idx].nout   = nout;
        tbl[idx].efirst = efirst;
        tbl[idx].ovf_at = ovf_at;
        tbl[idx].mode   = mode;
    endtask

    initial begin
        //          len start nout first ovf mode
        set_vec(0,  4, 4'h1,  4, 4'h4,  -1, 0);   // basic 1,2,3,4 -> 4..1
        set_vec(1,  1, 4'hA,  1, 4'hA,  -1, 0);   // single word
        set_vec(2, 18, 4'h0, 15, 4'hE,  15, 0);   // 0..17 -> 14..0
        set_vec(3, 15, 4'h3, 15, 4'h1,  -1, 1);   // alternating ready
        set_vec(4, 15, 4'h5, 15, 4'h3,  -1, 2);   // random stalls
        set_vec(5, 15, 4'h0, 15, 4'hE,  -1, 0);   // exactly full
        set_vec(6, 16, 4'h8, 15, 4'h6,  15, 0);   // s_last on discarded word

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 7; t++) begin
            ready_mode = tbl[t].mode;
            m_ready    = 1'b1;
            push_expected(tbl[t].efirst, tbl[t].nout);
            send_frame(tbl[t].len, tbl[t].start, tbl[t].ovf_at);
            wait_drain(tbl[t].nout, tbl[t].mode == 0);
            @(posedge clk);
            #1;
        end

        // Back-to-back frames: the second waits on s_ready during the first drain.
        ready_mode = 0;
        m_ready    = 1'b1;
        push_expected(4'h6, 2);
        push_expected(4'h9, 3);
        send_frame(2, 4'h5, -1);
        send_frame(3, 4'h7, -1);
        wait_drain(3, 1'b1);
        @(posedge clk);
        #1;

        // Reset after two of eight output words.
        n_out = 0;
        push_expected(4'h8, 8);
        send_frame(8, 4'h1, -1);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (n_out >= 2) break;
        end
        chk("outputs_before_reset", n_out, 2);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset("mid_drain");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_expected(4'h4, 2);
        send_frame(2, 4'h3, -1);
        wait_drain(2, 1'b1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
